// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eater_pkg
// Description : Shared constants and state encoding for the program-RAM
//               loader.
//               Contents:
//                 ADDR_W, DATA_W, MEM_DEPTH : RAM geometry.
//                 PTR_W                     : pointer width. One bit wider
//                                             than the address so that a
//                                             full 16-byte load can count
//                                             to 16.
//                 loader_state_e            : loader FSM states.
//                 sat_len()                 : maps a requested length to the
//                                             effective byte count.
// Revision    : 1.0 - initial release
// ============================================================================
package eater_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 16;
  localparam int PTR_W     = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    VERIFY = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_e;

  // A requested length of 0, or any length beyond the RAM depth, means a
  // full-depth load.
  function automatic logic [PTR_W-1:0] sat_len(input logic [PTR_W-1:0] len);
    if ((len == '0) || (len > PTR_W'(MEM_DEPTH))) begin
      return PTR_W'(MEM_DEPTH);
    end
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_if
// Description : Bundles the byte stream and the program-RAM pins of the
//               loader.
//               Signals:
//                 s_data, s_valid, s_ready : byte stream handshake.
//                 mem_address              : RAM address.
//                 ri                       : RAM write enable.
//                 ro                       : RAM read enable.
//                 mem_wdata                : RAM write data.
//                 mem_rdata                : RAM read data.
//               Modports:
//                 master : the loader side.
//                 slave  : the stream source and RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_loader_if;
  import eater_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              ri;
  logic              ro;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  s_data, s_valid, mem_rdata,
    output s_ready, mem_address, ri, ro, mem_wdata
  );

  modport slave (
    output s_data, s_valid, mem_rdata,
    input  s_ready, mem_address, ri, ro, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/ram_loader_byte_sum.sv
`default_nettype none
// ============================================================================
// Module      : byte_sum
// Description : Clearable 8-bit accumulator that wraps modulo 256.
//               Ports:
//                 clk, rst_n : clock, asynchronous active-low reset.
//                 i_clr      : synchronous clear. Takes priority over i_en.
//                 i_en       : adds i_din to the running sum.
//                 i_din      : byte to add.
//                 o_sum      : current sum.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_sum
  import eater_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_clr,
  input  wire logic              i_en,
  input  wire logic [DATA_W-1:0] i_din,
  output logic      [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + i_din;
    end
  end

  assign o_sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Fills the program RAM from a byte stream, reads it back, and
//               compares a modulo-256 sum of the written bytes against the
//               sum of the bytes read back. The CPU is held in reset while
//               the loader owns the RAM.
//               Ports:
//                 clk, rst_n : clock, asynchronous active-low reset.
//                 start      : load request. Ignored while busy.
//                 load_len   : byte count. 0, or any value above 16, means 16.
//                 bus        : stream and RAM pins (master modport).
//                 busy       : loader owns the RAM.
//                 cpu_hold   : CPU reset hold. Equal to busy.
//                 done       : sticky "load verified" flag.
//                 error      : sticky "checksum mismatch" flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader
  import eater_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            start,
  input  wire logic [ADDR_W:0] load_len,
  ram_loader_if.master         bus,
  output logic                 busy,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
);

  loader_state_e     r_state, w_state;
  logic [PTR_W-1:0]  r_len,   w_len;
  logic [PTR_W-1:0]  r_wptr,  w_wptr;
  logic [PTR_W-1:0]  r_rptr,  w_rptr;
  logic [ADDR_W-1:0] r_addr,  w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic              r_ri,    w_ri;
  logic              r_done,  w_done;
  logic              r_error, w_error;

  logic              w_start_ok;
  logic              w_xfer;
  logic              w_verify;
  logic [PTR_W-1:0]  w_wptr_inc;
  logic [PTR_W-1:0]  w_rptr_inc;
  logic [DATA_W-1:0] w_lsum;
  logic [DATA_W-1:0] w_vsum;

  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE) ||
                                (r_state == ERROR));
  assign w_xfer     = (r_state == LOAD) && bus.s_valid;
  assign w_verify   = (r_state == VERIFY);
  assign w_wptr_inc = r_wptr + PTR_W'(1);
  assign w_rptr_inc = r_rptr + PTR_W'(1);

  // --------------------------------------------------------------------------
  // Running sums of the bytes written and of the bytes read back.
  // --------------------------------------------------------------------------
  byte_sum u_lsum (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_en  (w_xfer),
    .i_din (bus.s_data),
    .o_sum (w_lsum)
  );

  byte_sum u_vsum (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_en  (w_verify),
    .i_din (bus.mem_rdata),
    .o_sum (w_vsum)
  );

  // --------------------------------------------------------------------------
  // Register bank
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ri    <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state;
      r_len   <= w_len;
      r_wptr  <= w_wptr;
      r_rptr  <= w_rptr;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_ri    <= w_ri;
      r_done  <= w_done;
      r_error <= w_error;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state = r_state;
    w_len   = r_len;
    w_wptr  = r_wptr;
    w_rptr  = r_rptr;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_ri    = 1'b0;       // a write pulse lasts exactly one cycle per transfer
    w_done  = r_done;
    w_error = r_error;

    case (r_state)
      IDLE, DONE, ERROR: begin
        if (w_start_ok) begin
          w_state = LOAD;
          w_len   = sat_len(load_len);
          w_wptr  = '0;
          w_rptr  = '0;
          w_done  = 1'b0;
          w_error = 1'b0;
        end
      end

      LOAD: begin
        if (w_xfer) begin
          w_ri    = 1'b1;
          w_addr  = r_wptr[ADDR_W-1:0];
          w_wdata = bus.s_data;
          w_wptr  = w_wptr_inc;
          if (w_wptr_inc == r_len) begin
            w_state = DRAIN;
          end
        end
      end

      // Lets the final write pulse finish before reads start on the RAM.
      DRAIN: begin
        w_rptr  = '0;
        w_state = VERIFY;
      end

      VERIFY: begin
        w_rptr = w_rptr_inc;
        if (w_rptr_inc == r_len) begin
          w_state = CHECK;
        end
      end

      CHECK: begin
        if (w_lsum == w_vsum) begin
          w_state = DONE;
          w_done  = 1'b1;
        end else begin
          w_state = ERROR;
          w_error = 1'b1;
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // During readback the address follows the read pointer directly. At all
  // other times it holds the address of the last write.
  assign bus.s_ready     = (r_state == LOAD);
  assign bus.ro          = w_verify;
  assign bus.mem_address = w_verify ? r_rptr[ADDR_W-1:0] : r_addr;
  assign bus.ri          = r_ri;
  assign bus.mem_wdata   = r_wdata;

  assign busy     = (r_state == LOAD) || (r_state == DRAIN) ||
                    (r_state == VERIFY) || (r_state == CHECK);
  assign cpu_hold = busy;
  assign done     = r_done;
  assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_loader
// Description : Self-checking bench for ram_loader. It contains:
//                 - a behavioural RAM with an optional bit flip on readback,
//                 - a stream driver,
//                 - expectations derived from the byte list and the
//                   observed stream acceptance cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] load_len;
  logic       busy;
  logic       cpu_hold;
  logic       done;
  logic       error;

  ram_loader_if bus ();

  ram_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_len (load_len),
    .bus      (bus),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  int   cyc;
  int   n_checks;
  int   n_pass;
  int   overlap;
  bit   flip_en;
  ev_t  wr_q[$];
  ev_t  rd_q[$];
  logic [7:0] mem [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous write, combinational read. When enabled, bit 0 of
  // the byte read from address 2 is flipped.
  always @(posedge clk) if (bus.ri) mem[bus.mem_address] <= bus.mem_wdata;
  assign bus.mem_rdata = bus.ro ?
      (mem[bus.mem_address] ^ {7'd0, flip_en && (bus.mem_address == 4'd2)}) : 8'h00;

  // Bus monitor
  always @(negedge clk) begin
    if (bus.ri) wr_q.push_back('{cyc, int'(bus.mem_address), int'(bus.mem_wdata)});
    if (bus.ro) rd_q.push_back('{cyc, int'(bus.mem_address), 0});
    if (bus.ri && bus.ro) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One complete load. gap: 0 = s_valid always high, 1 = toggling, 2 = random.
  // inj pulses start, with a different length, in LOAD and in the first VERIFY
  // cycle. Both pulses must be ignored.
  task automatic run_load(input logic [4:0] len_in, input logic [7:0] bytes[$],
                          input int gap, input bit corrupt, input bit inj);
    int n, idx, guard, t0, last, dcyc, s_exp, s_ret, nw, nr;
    int acc[$];
    bit rdy, ok;
    n = ((len_in == 5'd0) || (len_in > 5'd16)) ? 16 : int'(len_in);
    wr_q.delete(); rd_q.delete(); overlap = 0; flip_en = corrupt;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1; load_len = len_in;
    @(posedge clk); #1;
    start = 1'b0;
    check("flags_cleared", 32'({done, error}), 0);
    check("busy_in_load", 32'(busy), 1);
    idx = 0; guard = 0;
    while (idx < n && guard < 300) begin
      case (gap)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (guard % 2 == 0);
        default: bus.s_valid = 1'($urandom % 2);
      endcase
      bus.s_data = bytes[idx];
      start    = inj && (guard == 1);
      load_len = inj ? 5'd3 : len_in;
      rdy = bus.s_ready;
      @(posedge clk); #1;
      if (bus.s_valid && rdy) begin
        acc.push_back(cyc - 1 - t0);
        idx++;
      end
      guard++;
    end
    bus.s_valid = 1'b0; start = 1'b0;
    check("load_accepts", idx, n);
    last = (acc.size() > 0) ? acc[acc.size()-1] : 0;
    if (inj) begin
      @(posedge clk); #1;
      start = 1'b1; load_len = 5'd2;
      @(posedge clk); #1;
      start = 1'b0;
    end
    guard = 0;
    while (!(done || error) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    dcyc = cyc - t0;

    s_exp = 0; s_ret = 0;
    for (int i = 0; i < n; i++) begin
      s_exp += int'(bytes[i]);
      s_ret += int'(bytes[i] ^ ((corrupt && i == 2) ? 8'h01 : 8'h00));
    end
    ok = ((s_exp % 256) == (s_ret % 256));

    check("done_cycle", dcyc, last + n + 3);
    check("done", 32'(done), 32'(ok));
    check("error", 32'(error), 32'(!ok));
    check("cpu_hold_released", 32'(cpu_hold), 0);
    check("wr_count", wr_q.size(), n);
    nw = (wr_q.size() < n) ? wr_q.size() : n;
    for (int i = 0; i < nw; i++) begin
      check($sformatf("wr_addr[%0d]", i), wr_q[i].addr, i);
      check($sformatf("wr_data[%0d]", i), wr_q[i].data, int'(bytes[i]));
      check($sformatf("wr_cycle[%0d]", i), wr_q[i].cyc - t0, acc[i] + 1);
    end
    check("rd_count", rd_q.size(), n);
    nr = (rd_q.size() < n) ? rd_q.size() : n;
    for (int i = 0; i < nr; i++) begin
      check($sformatf("rd_addr[%0d]", i), rd_q[i].addr, i);
      check($sformatf("rd_cycle[%0d]", i), rd_q[i].cyc - t0, last + 2 + i);
    end
    check("ri_ro_overlap", overlap, 0);
    for (int i = 0; i < n; i++) check($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(bytes[i]));
    flip_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b[$];
    logic [4:0] len;
    cyc = 0; n_checks = 0; n_pass = 0; flip_en = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset held with start and s_valid asserted
    rst_n = 1'b0; start = 1'b1; load_len = 5'd5;
    bus.s_valid = 1'b1; bus.s_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.s_ready, bus.mem_address, bus.ri, bus.ro,
                               bus.mem_wdata, busy, cpu_hold, done, error}), 0);
    start = 1'b0; bus.s_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(busy), 0);

    // Reset in the middle of LOAD
    @(posedge clk); #1;
    start = 1'b1; load_len = 5'd8; bus.s_valid = 1'b1; bus.s_data = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ri_before_reset", 32'(bus.ri), 1);
    check("hold_before_reset", 32'(cpu_hold), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ri_async_reset", 32'(bus.ri), 0);
    check("hold_async_reset", 32'(cpu_hold), 0);
    bus.s_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Basic load
    b = '{8'h53, 8'h4F, 8'h1F, 8'hE0, 8'hF0};
    run_load(5'd5, b, 0, 1'b0, 1'b0);

    // Gapped stream
    b = '{8'h12, 8'h34, 8'h56};
    run_load(5'd3, b, 1, 1'b0, 1'b0);

    // Full depth
    b.delete();
    for (int i = 0; i < 16; i++) b.push_back(8'(i));
    run_load(5'd0, b, 0, 1'b0, 1'b0);

    // Corrupted readback
    b.delete();
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    run_load(5'd6, b, 0, 1'b1, 1'b0);

    // Restart from ERROR. Start pulses in LOAD and VERIFY are ignored.
    b.delete();
    for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
    run_load(5'd5, b, 0, 1'b0, 1'b1);

    // Saturating length
    b.delete();
    for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
    run_load(5'd20, b, 2, 1'b0, 1'b0);

    // Random loads
    for (int k = 0; k < 4; k++) begin
      b.delete();
      for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
      len = 5'($urandom_range(0, 20));
      run_load(len, b, 2, 1'($urandom % 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
